cache_fill_ctrl: RTL and testbench



---
 rtl/cache_fill_ctrl_pkg.sv | 48 ++++
 rtl/fill_word_counter.sv | 35 +++
 rtl/cache_fill_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_ctrl_pkg.sv
// Shared types and helpers for the cache-line fill
// controller and its word counters.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    TAG
  } fill_state_t;

  // Ceiling log2 for elaboration-time widths.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Address with the in-line offset bits cleared.
  function automatic int line_base(
    input int addr,
    input int off_w
  );
    return addr & ~((1 << off_w) - 1);
  endfunction

  // Word index of a byte address within its line.
  function automatic int word_off(
    input int addr,
    input int off_w,
    input int wsh
  );
    return (addr >> wsh) & ((1 << (off_w - wsh)) - 1);
  endfunction

  // Byte address of word idx inside an aligned line.
  function automatic int word_addr(
    input int base,
    input int idx,
    input int wsh
  );
    return base + (idx << wsh);
  endfunction

endpackage

// File: rtl/fill_word_counter.sv
// Word counter for writeback, read issue and read
// receive; also yields the wrapped line word index.
module fill_word_counter
  import cache_pkg::*;
#(
  parameter int BLOCK_WORDS = 8,
  parameter int TERM = BLOCK_WORDS - 1,
  localparam int IDX_W = clog2(BLOCK_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W:0]   count,
  output logic [IDX_W-1:0] idx,
  output logic             tc
);

  localparam logic [IDX_W:0] TERM_CNT = (IDX_W + 1)'(TERM);

  // Count accepted steps; cleared between line fills.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Index wraps naturally since the line is 2^IDX_W words.
  assign idx = start + count[IDX_W-1:0];
  assign tc  = (count == TERM_CNT);

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache-line fill controller: optional dirty-victim
// writeback, then in-order or critical-word-first fill.
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int WORD_BYTES = 2,
  parameter bit WB_EN = 1'b1,
  parameter bit CWF = 1'b0,
  localparam int IDX_W = clog2(BLOCK_WORDS),
  localparam int OFF_W = clog2(BLOCK_WORDS * WORD_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_address,
  input  logic              stall,
  input  logic              mem_data_valid,
  output logic              fsm_busy,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [IDX_W-1:0]  wb_word_index,
  output logic              wen_cache,
  output logic [IDX_W-1:0]  word_enable,
  output logic              wen_tag,
  output logic              fill_done
);

  localparam int WSH = clog2(WORD_BYTES);

  fill_state_t state, state_nx;

  logic [ADDR_W-1:0] fill_base;
  logic [ADDR_W-1:0] victim_base;
  logic [IDX_W-1:0]  start_idx;

  logic accept;
  logic cnt_clr;
  logic wb_step;
  logic iss_step;
  logic rcv_step;

  logic [IDX_W:0]   wb_cnt_unused;
  logic [IDX_W:0]   iss_cnt;
  logic [IDX_W:0]   rcv_cnt;
  logic [IDX_W-1:0] wb_idx;
  logic [IDX_W-1:0] iss_idx;
  logic [IDX_W-1:0] rcv_idx;
  logic wb_last;
  logic iss_full;
  logic rcv_last;

  assign accept  = (state == IDLE) && miss_detected;
  assign cnt_clr = (state == IDLE);

  // State register; reset aborts any fill in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Latch line bases and fill start word on accepted miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_base   <= '0;
      victim_base <= '0;
      start_idx   <= '0;
    end else if (accept) begin
      fill_base <= ADDR_W'(
        line_base(int'(miss_address), OFF_W));
      victim_base <= ADDR_W'(
        line_base(int'(victim_address), OFF_W));
      start_idx <= CWF ? IDX_W'(
        word_off(int'(miss_address), OFF_W, WSH)) : '0;
    end
  end

  fill_word_counter #(
    .BLOCK_WORDS(BLOCK_WORDS),
    .TERM(BLOCK_WORDS - 1)
  ) u_wb_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en(wb_step),
    .start('0),
    .count(wb_cnt_unused),
    .idx(wb_idx),
    .tc(wb_last)
  );

  fill_word_counter #(
    .BLOCK_WORDS(BLOCK_WORDS),
    .TERM(BLOCK_WORDS)
  ) u_iss_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en(iss_step),
    .start(start_idx),
    .count(iss_cnt),
    .idx(iss_idx),
    .tc(iss_full)
  );

  fill_word_counter #(
    .BLOCK_WORDS(BLOCK_WORDS),
    .TERM(BLOCK_WORDS - 1)
  ) u_rcv_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en(rcv_step),
    .start(start_idx),
    .count(rcv_cnt),
    .idx(rcv_idx),
    .tc(rcv_last)
  );

  // Next state and request/write strobes.
  always_comb begin
    state_nx      = state;
    fsm_busy      = 1'b1;
    mem_read_en   = 1'b0;
    mem_write_en  = 1'b0;
    mem_address   = '0;
    wb_word_index = '0;
    wen_cache     = 1'b0;
    word_enable   = '0;
    wen_tag       = 1'b0;
    fill_done     = 1'b0;
    wb_step       = 1'b0;
    iss_step      = 1'b0;
    rcv_step      = 1'b0;
    unique case (state)
      IDLE: begin
        fsm_busy = miss_detected;
        if (miss_detected) begin
          state_nx = (WB_EN && victim_dirty) ? WB : FILL;
        end
      end
      WB: begin
        if (!stall) begin
          wb_step       = 1'b1;
          mem_write_en  = 1'b1;
          wb_word_index = wb_idx;
          mem_address   = ADDR_W'(word_addr(
            int'(victim_base), int'(wb_idx), WSH));
          if (wb_last) state_nx = FILL;
        end
      end
      FILL: begin
        if (!stall && !iss_full) begin
          iss_step    = 1'b1;
          mem_read_en = 1'b1;
          mem_address = ADDR_W'(word_addr(
            int'(fill_base), int'(iss_idx), WSH));
        end
        // Memory cannot be held off, so accept under stall.
        if (mem_data_valid && (rcv_cnt < iss_cnt)) begin
          rcv_step    = 1'b1;
          wen_cache   = 1'b1;
          word_enable = rcv_idx;
          if (rcv_last) state_nx = TAG;
        end
      end
      TAG: begin
        wen_tag   = 1'b1;
        fill_done = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Randomised bench: in-order and critical-word-first
// controllers against a line-level reference model.
module tb_cache_fill_ctrl;

  localparam int AW  = 16;
  localparam int BW  = 8;
  localparam int WBY = 2;
  localparam int IW  = 3;
  localparam int LB  = BW * WBY;

  localparam int P_IDLE = 0;
  localparam int P_WB   = 1;
  localparam int P_FILL = 2;
  localparam int P_TAG  = 3;

  logic clk = 1'b0;
  logic rst;
  logic miss_detected;
  logic [AW-1:0] miss_address;
  logic victim_dirty;
  logic [AW-1:0] victim_address;
  logic stall;
  logic mem_data_valid;

  logic [1:0] busy, rd, wr, wc, wt, fd;
  logic [1:0][AW-1:0] addr;
  logic [1:0][IW-1:0] wbi, we;

  always #5 clk = ~clk;

  cache_fill_ctrl #(.CWF(1'b0)) dut0 (
    .clk(clk),
    .rst(rst),
    .miss_detected(miss_detected),
    .miss_address(miss_address),
    .victim_dirty(victim_dirty),
    .victim_address(victim_address),
    .stall(stall),
    .mem_data_valid(mem_data_valid),
    .fsm_busy(busy[0]),
    .mem_read_en(rd[0]),
    .mem_write_en(wr[0]),
    .mem_address(addr[0]),
    .wb_word_index(wbi[0]),
    .wen_cache(wc[0]),
    .word_enable(we[0]),
    .wen_tag(wt[0]),
    .fill_done(fd[0])
  );

  cache_fill_ctrl #(.CWF(1'b1)) dut1 (
    .clk(clk),
    .rst(rst),
    .miss_detected(miss_detected),
    .miss_address(miss_address),
    .victim_dirty(victim_dirty),
    .victim_address(victim_address),
    .stall(stall),
    .mem_data_valid(mem_data_valid),
    .fsm_busy(busy[1]),
    .mem_read_en(rd[1]),
    .mem_write_en(wr[1]),
    .mem_address(addr[1]),
    .wb_word_index(wbi[1]),
    .wen_cache(wc[1]),
    .word_enable(we[1]),
    .wen_tag(wt[1]),
    .fill_done(fd[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(
    input string tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model: where the controller is in the line
  // transfer, as word counts, plus the captured miss.
  int ph = P_IDLE;
  int nwr = 0, niss = 0, nrcv = 0, woff = 0;
  logic [AW-1:0] fb = '0, vb = '0;
  int cyc = 0;
  int rq[$];

  // Stimulus knobs.
  int p_stall = 0, p_spur = 0, p_miss = 0, p_rst = 0;
  int lat_lo = 2, lat_hi = 2;
  bit pend = 0, pd = 0;
  logic [AW-1:0] pa = '0, pv = '0;
  bit stall_trig = 0, rst_trig = 0;
  int hold = 0;

  task automatic step();
    logic [AW-1:0] ea0, ea1;
    logic [IW-1:0] ewbi, ewe0, ewe1;
    bit bz, rdx, wrx, wcx, wtx;
    int t;
    logic [63:0] e0, e1, g0, g1;
    @(negedge clk);
    rst = 1'b0;
    if (rst_trig && ph == P_FILL && nrcv == 4) begin
      rst = 1'b1;
      rst_trig = 0;
    end else if ($urandom_range(999) < p_rst) begin
      rst = 1'b1;
    end
    if (stall_trig && ph == P_FILL && niss == 2) begin
      hold = 3;
      stall_trig = 0;
    end
    if (hold > 0) begin
      stall = 1'b1;
      hold--;
    end else begin
      stall = ($urandom_range(99) < p_stall);
    end
    if (pend && ph == P_IDLE) begin
      miss_detected = 1'b1;
      miss_address = pa;
      victim_address = pv;
      victim_dirty = pd;
      pend = 0;
    end else begin
      miss_detected = ($urandom_range(99) < p_miss);
      miss_address = AW'($urandom);
      victim_address = AW'($urandom);
      victim_dirty = $urandom_range(1);
    end
    while (rq.size() > 0 && rq[0] < cyc) void'(rq.pop_front());
    mem_data_valid = ($urandom_range(99) < p_spur);
    if (rq.size() > 0 && rq[0] == cyc) begin
      mem_data_valid = 1'b1;
      void'(rq.pop_front());
    end
    #1;
    bz = 0; rdx = 0; wrx = 0; wcx = 0; wtx = 0;
    ea0 = '0; ea1 = '0; ewbi = '0; ewe0 = '0; ewe1 = '0;
    case (ph)
      P_IDLE: bz = miss_detected;
      P_WB: begin
        bz = 1;
        if (!stall) begin
          wrx = 1;
          ea0 = AW'(vb + nwr * WBY);
          ea1 = ea0;
          ewbi = IW'(nwr);
        end
      end
      P_FILL: begin
        bz = 1;
        if (!stall && niss < BW) begin
          rdx = 1;
          ea0 = AW'(fb + (niss % BW) * WBY);
          ea1 = AW'(fb + ((woff + niss) % BW) * WBY);
        end
        if (mem_data_valid && nrcv < niss) begin
          wcx = 1;
          ewe0 = IW'(nrcv % BW);
          ewe1 = IW'((woff + nrcv) % BW);
        end
      end
      default: begin
        bz = 1;
        wtx = 1;
      end
    endcase
    e0 = 64'({bz, rdx, wrx, wcx, wtx, wtx, ea0, ewbi, ewe0});
    e1 = 64'({bz, rdx, wrx, wcx, wtx, wtx, ea1, ewbi, ewe1});
    g0 = 64'({busy[0], rd[0], wr[0], wc[0], wt[0], fd[0],
              addr[0], wbi[0], we[0]});
    g1 = 64'({busy[1], rd[1], wr[1], wc[1], wt[1], fd[1],
              addr[1], wbi[1], we[1]});
    check($sformatf("inorder_c%0d", cyc), g0, e0);
    check($sformatf("cwf_c%0d", cyc), g1, e1);
    // Advance the model for the coming clock edge.
    if (rdx) begin
      t = cyc + $urandom_range(lat_hi, lat_lo);
      if (rq.size() > 0 && t <= rq[$]) t = rq[$] + 1;
      rq.push_back(t);
    end
    case (ph)
      P_IDLE: if (miss_detected) begin
        fb = miss_address & ~AW'(LB - 1);
        vb = victim_address & ~AW'(LB - 1);
        woff = (int'(miss_address) % LB) / WBY;
        nwr = 0; niss = 0; nrcv = 0;
        ph = victim_dirty ? P_WB : P_FILL;
      end
      P_WB: if (wrx) begin
        nwr++;
        if (nwr == BW) ph = P_FILL;
      end
      P_FILL: begin
        if (wcx) nrcv++;
        if (rdx) niss++;
        if (nrcv == BW) ph = P_TAG;
      end
      default: ph = P_IDLE;
    endcase
    if (rst) begin
      ph = P_IDLE;
      nwr = 0; niss = 0; nrcv = 0;
      rq.delete();
      hold = 0;
    end
    cyc++;
  endtask

  task automatic run_txn(
    input logic [AW-1:0] a,
    input logic [AW-1:0] v,
    input bit d
  );
    int n;
    n = 0;
    pa = a; pv = v; pd = d; pend = 1;
    do begin
      step();
      n++;
    end while ((pend || ph != P_IDLE) && n < 300);
    check("txn_complete", 64'({pend, ph != P_IDLE}), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address = '0;
    victim_dirty = 1'b0;
    victim_address = '0;
    stall = 1'b0;
    mem_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    repeat (3) step();
    run_txn(16'h1236, 16'h0000, 1'b0);
    run_txn(16'h123A, 16'h0000, 1'b0);
    run_txn(16'h1230, 16'h4567, 1'b1);
    stall_trig = 1;
    run_txn(16'h1230, 16'h0000, 1'b0);
    rst_trig = 1;
    run_txn(16'h1230, 16'h0000, 1'b0);
    repeat (2) step();
    run_txn(16'h2000, 16'h0000, 1'b0);
    p_spur = 50;
    repeat (10) step();
    p_spur = 0;
    p_miss = 50;
    run_txn(16'h3456, 16'h789A, 1'b0);
    p_miss = 0;
    p_stall = 30; p_spur = 10; p_miss = 20;
    p_rst = 3; lat_lo = 1; lat_hi = 4;
    repeat (4000) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
